// File: rtl/pixel_dispatcher.sv
// pixel_dispatcher
//
// Walks one frame in raster order (x fastest, then y). For each pixel it
// computes the complex constant c, launches one depth calculation, waits for
// the calculator's done level and then offers the result on a valid/ready
// pixel stream. The value of c is accumulated incrementally from the latched
// origin and step, so no multiplier is needed.
//
// Ports
//   sysclk, reset          clock (rising edge) and asynchronous active-high reset
//   frame_start            begins a frame; sampled only while idle
//   re_origin, im_origin   c of pixel (0,0); latched when a frame is accepted
//   step                   per-pixel increment; latched when a frame is accepted
//   calc_start             one-cycle launch pulse to the calculator
//   calc_x, calc_y         coordinates of the pixel being calculated
//   calc_re_c, calc_im_c   c for the calculator, stable until the result is captured
//   calc_done, calc_depth  calculator done level and its depth result
//   pix_valid, pix_ready   result stream handshake
//   pix_x, pix_y           coordinates of the result pixel
//   pix_depth              escape depth of the result pixel
//   pix_last               marks the final pixel of the frame
//   busy                   high while a frame is in progress
//   frame_done             one-cycle pulse after the final pixel handshake
module pixel_dispatcher #(
    parameter int FRAC        = 28,
    parameter int WORD_LENGTH = 32,
    parameter int H_RES       = 640,
    parameter int V_RES       = 480
) (
    input  logic                   sysclk,
    input  logic                   reset,
    input  logic                   frame_start,
    input  logic [WORD_LENGTH-1:0] re_origin,
    input  logic [WORD_LENGTH-1:0] im_origin,
    input  logic [WORD_LENGTH-1:0] step,
    output logic                   calc_start,
    output logic [10:0]            calc_x,
    output logic [10:0]            calc_y,
    output logic [WORD_LENGTH-1:0] calc_re_c,
    output logic [WORD_LENGTH-1:0] calc_im_c,
    input  logic                   calc_done,
    input  logic [10:0]            calc_depth,
    output logic                   pix_valid,
    input  logic                   pix_ready,
    output logic [10:0]            pix_x,
    output logic [10:0]            pix_y,
    output logic [10:0]            pix_depth,
    output logic                   pix_last,
    output logic                   busy,
    output logic                   frame_done
);

    localparam logic [10:0] X_LAST = 11'(H_RES - 1);
    localparam logic [10:0] Y_LAST = 11'(V_RES - 1);

    // The fixed-point format only matters to the calculator; this block adds
    // and subtracts raw words. A fractional width that does not fit the word
    // shows up as a named empty block in the elaborated hierarchy.
    if (FRAC < 0 || FRAC >= WORD_LENGTH) begin : g_frac_out_of_range
    end

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        GUARD,
        WAIT,
        EMIT
    } state_t;

    state_t                 state_q, state_d;
    logic [10:0]            x_q, x_d;
    logic [10:0]            y_q, y_d;
    logic [WORD_LENGTH-1:0] re_origin_q, re_origin_d;
    logic [WORD_LENGTH-1:0] im_origin_q, im_origin_d;
    logic [WORD_LENGTH-1:0] step_q, step_d;
    logic [WORD_LENGTH-1:0] re_c_q, re_c_d;
    logic [WORD_LENGTH-1:0] im_c_q, im_c_d;
    logic                   calc_start_q, calc_start_d;
    logic                   pix_valid_q, pix_valid_d;
    logic [10:0]            pix_x_q, pix_x_d;
    logic [10:0]            pix_y_q, pix_y_d;
    logic [10:0]            pix_depth_q, pix_depth_d;
    logic                   pix_last_q, pix_last_d;
    logic                   busy_q, busy_d;
    logic                   frame_done_q, frame_done_d;

    // Next-state logic. calc_start is raised on the transition into LAUNCH so
    // the registered pulse lines up exactly with the LAUNCH cycle. GUARD
    // exists because calc_done is a level left over from the previous pixel
    // until the calculator has seen the new start.
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        re_origin_d  = re_origin_q;
        im_origin_d  = im_origin_q;
        step_d       = step_q;
        re_c_d       = re_c_q;
        im_c_d       = im_c_q;
        calc_start_d = 1'b0;
        pix_valid_d  = pix_valid_q;
        pix_x_d      = pix_x_q;
        pix_y_d      = pix_y_q;
        pix_depth_d  = pix_depth_q;
        pix_last_d   = pix_last_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                // A request coinciding with the frame_done pulse is dropped.
                if (frame_start && !frame_done_q) begin
                    re_origin_d  = re_origin;
                    im_origin_d  = im_origin;
                    step_d       = step;
                    x_d          = 11'd0;
                    y_d          = 11'd0;
                    re_c_d       = re_origin;
                    im_c_d       = im_origin;
                    busy_d       = 1'b1;
                    calc_start_d = 1'b1;
                    state_d      = LAUNCH;
                end
            end
            LAUNCH: state_d = GUARD;
            GUARD:  state_d = WAIT;
            WAIT: begin
                if (calc_done) begin
                    pix_x_d     = x_q;
                    pix_y_d     = y_q;
                    pix_depth_d = calc_depth;
                    pix_valid_d = 1'b1;
                    pix_last_d  = (x_q == X_LAST) && (y_q == Y_LAST);
                    state_d     = EMIT;
                end
            end
            EMIT: begin
                if (pix_ready) begin
                    pix_valid_d = 1'b0;
                    if (pix_last_q) begin
                        pix_last_d   = 1'b0;
                        busy_d       = 1'b0;
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        // Imaginary axis runs downward, so a new line subtracts.
                        if (x_q < X_LAST) begin
                            x_d    = x_q + 11'd1;
                            re_c_d = re_c_q + step_q;
                        end else begin
                            x_d    = 11'd0;
                            y_d    = y_q + 11'd1;
                            re_c_d = re_origin_q;
                            im_c_d = im_c_q - step_q;
                        end
                        calc_start_d = 1'b1;
                        state_d      = LAUNCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset returns to IDLE and clears every output at once.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            re_origin_q  <= '0;
            im_origin_q  <= '0;
            step_q       <= '0;
            re_c_q       <= '0;
            im_c_q       <= '0;
            calc_start_q <= 1'b0;
            pix_valid_q  <= 1'b0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            pix_depth_q  <= '0;
            pix_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            re_origin_q  <= re_origin_d;
            im_origin_q  <= im_origin_d;
            step_q       <= step_d;
            re_c_q       <= re_c_d;
            im_c_q       <= im_c_d;
            calc_start_q <= calc_start_d;
            pix_valid_q  <= pix_valid_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            pix_depth_q  <= pix_depth_d;
            pix_last_q   <= pix_last_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign calc_start = calc_start_q;
    assign calc_x     = x_q;
    assign calc_y     = y_q;
    assign calc_re_c  = re_c_q;
    assign calc_im_c  = im_c_q;
    assign pix_valid  = pix_valid_q;
    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;
    assign pix_depth  = pix_depth_q;
    assign pix_last   = pix_last_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pixel_dispatcher.sv
// tb_pixel_dispatcher
//
// Directed bench for pixel_dispatcher. The main instance runs a 4x2 frame
// against a behavioural calculator model; a second instance is a 1x1 frame
// whose calculator is driven by hand.
module tb_pixel_dispatcher;

    logic        sysclk = 1'b0;
    logic        reset;

    // 4x2 instance
    logic        frame_start;
    logic [31:0] re_origin, im_origin, step;
    logic        calc_start;
    logic [10:0] calc_x, calc_y;
    logic [31:0] calc_re_c, calc_im_c;
    logic        calc_done;
    logic [10:0] calc_depth;
    logic        pix_valid, pix_ready;
    logic [10:0] pix_x, pix_y, pix_depth;
    logic        pix_last, busy, frame_done;

    // 1x1 instance
    logic        s_frame_start;
    logic [31:0] s_re_origin, s_im_origin, s_step;
    logic        s_calc_start;
    logic [10:0] s_calc_x, s_calc_y;
    logic [31:0] s_calc_re_c, s_calc_im_c;
    logic        s_calc_done;
    logic [10:0] s_calc_depth;
    logic        s_pix_valid, s_pix_ready;
    logic [10:0] s_pix_x, s_pix_y, s_pix_depth;
    logic        s_pix_last, s_busy, s_frame_done;

    int total = 0;
    int bad   = 0;

    // Calculator model state
    int          model_lat;
    logic        stale_mode;
    int          cnt;
    logic        drop_pending;
    logic [10:0] pend_depth;

    // Launch / frame_done pulse counters
    int cs_count   = 0;
    int fd_count   = 0;
    int s_cs_count = 0;

    // Expected c values for the 4x2 frame with origin (-2.0, 1.0) and step 0.25
    logic [31:0] re_tab [4] = '{32'hE0000000, 32'hE4000000, 32'hE8000000, 32'hEC000000};
    logic [31:0] im_tab [2] = '{32'h10000000, 32'h0C000000};

    always #5 sysclk = ~sysclk;

    pixel_dispatcher #(.FRAC(28), .WORD_LENGTH(32), .H_RES(4), .V_RES(2)) dut (
        .sysclk(sysclk), .reset(reset), .frame_start(frame_start),
        .re_origin(re_origin), .im_origin(im_origin), .step(step),
        .calc_start(calc_start), .calc_x(calc_x), .calc_y(calc_y),
        .calc_re_c(calc_re_c), .calc_im_c(calc_im_c),
        .calc_done(calc_done), .calc_depth(calc_depth),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_depth(pix_depth),
        .pix_last(pix_last), .busy(busy), .frame_done(frame_done)
    );

    pixel_dispatcher #(.FRAC(28), .WORD_LENGTH(32), .H_RES(1), .V_RES(1)) dut1 (
        .sysclk(sysclk), .reset(reset), .frame_start(s_frame_start),
        .re_origin(s_re_origin), .im_origin(s_im_origin), .step(s_step),
        .calc_start(s_calc_start), .calc_x(s_calc_x), .calc_y(s_calc_y),
        .calc_re_c(s_calc_re_c), .calc_im_c(s_calc_im_c),
        .calc_done(s_calc_done), .calc_depth(s_calc_depth),
        .pix_valid(s_pix_valid), .pix_ready(s_pix_ready),
        .pix_x(s_pix_x), .pix_y(s_pix_y), .pix_depth(s_pix_depth),
        .pix_last(s_pix_last), .busy(s_busy), .frame_done(s_frame_done)
    );

    function automatic logic [10:0] depth_of(input logic [10:0] x, input logic [10:0] y);
        return 11'(x * 16 + y * 3 + 2);
    endfunction

    // Calculator model: done drops when start is seen (or one cycle later in
    // stale mode) and rises model_lat edges after the start.
    always @(posedge sysclk or posedge reset) begin
        if (reset) begin
            calc_done    <= 1'b0;
            calc_depth   <= '0;
            cnt          <= 0;
            drop_pending <= 1'b0;
            pend_depth   <= '0;
        end else if (calc_start) begin
            if (stale_mode) drop_pending <= 1'b1;
            else            calc_done    <= 1'b0;
            cnt        <= model_lat;
            pend_depth <= stale_mode ? 11'd37 : depth_of(calc_x, calc_y);
        end else begin
            if (drop_pending) begin
                calc_done    <= 1'b0;
                drop_pending <= 1'b0;
            end
            if (cnt > 0) begin
                cnt <= cnt - 1;
                if (cnt == 1) begin
                    calc_done  <= 1'b1;
                    calc_depth <= pend_depth;
                end
            end
        end
    end

    always @(negedge sysclk) begin
        if (calc_start === 1'b1)   cs_count++;
        if (frame_done === 1'b1)   fd_count++;
        if (s_calc_start === 1'b1) s_cs_count++;
    end

    task automatic wait_calc_start(output bit ok);
        ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (calc_start === 1'b1) ok = 1;
            else @(negedge sysclk);
        end
    endtask

    task automatic wait_pix_valid(output bit ok, output int lat);
        ok  = 0;
        lat = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (pix_valid === 1'b1) ok = 1;
            else begin
                @(negedge sysclk);
                lat++;
            end
        end
    endtask

    task automatic wait_frame_done(output bit ok);
        ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            if (frame_done === 1'b1) ok = 1;
            else @(negedge sysclk);
        end
    endtask

    task automatic pulse_frame_start();
        frame_start = 1'b1;
        @(negedge sysclk);
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge sysclk);
        total++;
        if ({calc_start, pix_valid, busy, frame_done, pix_last} !== 5'b0) begin
            bad++;
            $display("[TB] FAIL reset_flags got=%b want=00000",
                     {calc_start, pix_valid, busy, frame_done, pix_last});
        end
        total++;
        if ({calc_x, calc_y, calc_re_c, calc_im_c} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_calc got x=%0d y=%0d re=%h im=%h want all 0",
                     calc_x, calc_y, calc_re_c, calc_im_c);
        end
        total++;
        if ({pix_x, pix_y, pix_depth} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_pix got x=%0d y=%0d d=%0d want all 0", pix_x, pix_y, pix_depth);
        end
        reset = 1'b0;
        repeat (3) @(negedge sysclk);
        total++;
        if ({calc_start, busy} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL idle_after_reset got start/busy=%b want=00", {calc_start, busy});
        end
    endtask

    task automatic test_frame();
        bit ok;
        int lat, cs0, fd0;
        logic [10:0] ex, ey;
        pix_ready = 1'b1;
        cs0 = cs_count;
        fd0 = fd_count;
        pulse_frame_start();
        for (int p = 0; p < 8; p++) begin
            ex = 11'(p % 4);
            ey = 11'(p / 4);
            wait_calc_start(ok);
            total++;
            if (!ok) begin bad++; $display("[TB] FAIL frame_launch_timeout pixel=%0d", p); end
            total++;
            if ({calc_x, calc_y} !== {ex, ey}) begin
                bad++;
                $display("[TB] FAIL frame_calc_xy got=(%0d,%0d) want=(%0d,%0d)", calc_x, calc_y, ex, ey);
            end
            total++;
            if (calc_re_c !== re_tab[p % 4] || calc_im_c !== im_tab[p / 4]) begin
                bad++;
                $display("[TB] FAIL frame_c pixel=%0d got=%h/%h want=%h/%h",
                         p, calc_re_c, calc_im_c, re_tab[p % 4], im_tab[p / 4]);
            end
            wait_pix_valid(ok, lat);
            total++;
            if (!ok) begin bad++; $display("[TB] FAIL frame_valid_timeout pixel=%0d", p); end
            if (p == 0) begin
                total++;
                if (lat !== 7 || busy !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL frame_latency got=%0d busy=%b want=7 busy=1", lat, busy);
                end
            end
            total++;
            if ({pix_x, pix_y, pix_depth} !== {ex, ey, depth_of(ex, ey)}) begin
                bad++;
                $display("[TB] FAIL frame_pixel got=(%0d,%0d,%0d) want=(%0d,%0d,%0d)",
                         pix_x, pix_y, pix_depth, ex, ey, depth_of(ex, ey));
            end
            total++;
            if (pix_last !== (p == 7)) begin
                bad++;
                $display("[TB] FAIL frame_last pixel=%0d got=%b want=%b", p, pix_last, (p == 7));
            end
            @(negedge sysclk);
            if (p < 7) begin
                total++;
                if (calc_start !== 1'b1 || pix_valid !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL frame_relaunch got start=%b valid=%b want start=1 valid=0",
                             calc_start, pix_valid);
                end
            end
        end
        total++;
        if ({frame_done, busy, pix_valid, pix_last} !== 4'b1000) begin
            bad++;
            $display("[TB] FAIL frame_end got done/busy/valid/last=%b want=1000",
                     {frame_done, busy, pix_valid, pix_last});
        end
        @(negedge sysclk);
        total++;
        if (frame_done !== 1'b0 || (cs_count - cs0) !== 8 || (fd_count - fd0) !== 1) begin
            bad++;
            $display("[TB] FAIL frame_counts got done=%b starts=%0d dones=%0d want 0/8/1",
                     frame_done, cs_count - cs0, fd_count - fd0);
        end
    endtask

    task automatic test_backpressure();
        bit ok, stable;
        int lat;
        logic [10:0] sx, sy, sd;
        pix_ready = 1'b0;
        pulse_frame_start();
        wait_pix_valid(ok, lat);
        total++;
        if (!ok) begin bad++; $display("[TB] FAIL bp_valid_timeout"); end
        sx = pix_x;
        sy = pix_y;
        sd = pix_depth;
        total++;
        if ({sx, sy, sd} !== {11'd0, 11'd0, depth_of(11'd0, 11'd0)}) begin
            bad++;
            $display("[TB] FAIL bp_first_pixel got=(%0d,%0d,%0d) want=(0,0,2)", sx, sy, sd);
        end
        stable = 1;
        repeat (10) begin
            @(negedge sysclk);
            if (pix_valid !== 1'b1 || pix_x !== sx || pix_y !== sy || pix_depth !== sd
                || calc_start !== 1'b0) stable = 0;
        end
        total++;
        if (!stable) begin
            bad++;
            $display("[TB] FAIL bp_hold got valid=%b start=%b pix=(%0d,%0d,%0d) want held",
                     pix_valid, calc_start, pix_x, pix_y, pix_depth);
        end
        pix_ready = 1'b1;
        @(negedge sysclk);
        total++;
        if (pix_valid !== 1'b0 || calc_start !== 1'b1 || calc_x !== 11'd1) begin
            bad++;
            $display("[TB] FAIL bp_release got valid=%b start=%b x=%0d want 0/1/1",
                     pix_valid, calc_start, calc_x);
        end
        wait_frame_done(ok);
        total++;
        if (!ok) begin bad++; $display("[TB] FAIL bp_frame_done_timeout"); end
        @(negedge sysclk);
    endtask

    task automatic test_stale_done();
        bit ok;
        int lat;
        stale_mode = 1'b1;
        pulse_frame_start();
        wait_calc_start(ok);
        @(negedge sysclk);
        total++;
        if (calc_done !== 1'b1) begin
            bad++;
            $display("[TB] FAIL stale_setup got calc_done=%b in guard want=1", calc_done);
        end
        wait_pix_valid(ok, lat);
        total++;
        if (!ok || pix_depth !== 11'd37 || pix_x !== 11'd0) begin
            bad++;
            $display("[TB] FAIL stale_depth got depth=%0d x=%0d want depth=37 x=0", pix_depth, pix_x);
        end
        wait_frame_done(ok);
        total++;
        if (!ok) begin bad++; $display("[TB] FAIL stale_frame_done_timeout"); end
        @(negedge sysclk);
        stale_mode = 1'b0;
    endtask

    task automatic test_frame_start_ignored();
        bit ok;
        int lat;
        pix_ready = 1'b1;
        pulse_frame_start();
        for (int p = 0; p < 8; p++) begin
            wait_calc_start(ok);
            total++;
            if (!ok || calc_re_c !== re_tab[p % 4] || calc_im_c !== im_tab[p / 4]) begin
                bad++;
                $display("[TB] FAIL ignore_c pixel=%0d got=%h/%h want=%h/%h",
                         p, calc_re_c, calc_im_c, re_tab[p % 4], im_tab[p / 4]);
            end
            if (p == 0) begin
                // Request and new origin while busy must have no effect.
                re_origin   = 32'h0;
                im_origin   = 32'h0;
                step        = 32'h1;
                frame_start = 1'b1;
                repeat (3) @(negedge sysclk);
                frame_start = 1'b0;
            end
            wait_pix_valid(ok, lat);
            if (p < 7) @(negedge sysclk);
        end
        // Hold frame_start through the last handshake and the frame_done cycle.
        re_origin   = 32'hE0000000;
        im_origin   = 32'h10000000;
        step        = 32'h04000000;
        frame_start = 1'b1;
        @(negedge sysclk);
        total++;
        if (frame_done !== 1'b1) begin
            bad++;
            $display("[TB] FAIL ignore_done_pulse got=%b want=1", frame_done);
        end
        @(negedge sysclk);
        total++;
        if (busy !== 1'b0 || calc_start !== 1'b0) begin
            bad++;
            $display("[TB] FAIL ignore_in_done_cycle got busy=%b start=%b want 0/0", busy, calc_start);
        end
        @(negedge sysclk);
        frame_start = 1'b0;
        total++;
        if ({calc_start, busy, calc_x, calc_y} !== {2'b11, 22'd0} || calc_re_c !== 32'hE0000000) begin
            bad++;
            $display("[TB] FAIL ignore_restart got start=%b busy=%b xy=(%0d,%0d) re=%h want 1 1 (0,0) e0000000",
                     calc_start, busy, calc_x, calc_y, calc_re_c);
        end
        wait_frame_done(ok);
        total++;
        if (!ok) begin bad++; $display("[TB] FAIL ignore_frame_done_timeout"); end
        @(negedge sysclk);
    endtask

    task automatic test_reset_mid_emit();
        bit ok;
        int lat, cs0;
        pix_ready = 1'b0;
        pulse_frame_start();
        wait_pix_valid(ok, lat);
        total++;
        if (!ok) begin bad++; $display("[TB] FAIL rst_valid_timeout"); end
        #2 reset = 1'b1;
        #1;
        total++;
        if ({calc_start, pix_valid, busy, frame_done, pix_last} !== 5'b0
            || {pix_x, pix_y, pix_depth, calc_x, calc_y} !== '0 || {calc_re_c, calc_im_c} !== '0) begin
            bad++;
            $display("[TB] FAIL rst_async got start/valid/busy/done/last=%b depth=%0d re=%h want all 0",
                     {calc_start, pix_valid, busy, frame_done, pix_last}, pix_depth, calc_re_c);
        end
        @(negedge sysclk);
        reset     = 1'b0;
        pix_ready = 1'b1;
        cs0       = cs_count;
        repeat (20) @(negedge sysclk);
        total++;
        if ((cs_count - cs0) !== 0 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rst_quiet got starts=%0d busy=%b want 0/0", cs_count - cs0, busy);
        end
    endtask

    task automatic test_single_pixel();
        bit ok;
        int c0;
        c0 = s_cs_count;
        s_frame_start = 1'b1;
        @(negedge sysclk);
        s_frame_start = 1'b0;
        total++;
        if (s_calc_start !== 1'b1 || s_calc_re_c !== 32'h12345678 || s_calc_im_c !== 32'hFEDCBA98) begin
            bad++;
            $display("[TB] FAIL one_launch got start=%b re=%h im=%h want 1 12345678 fedcba98",
                     s_calc_start, s_calc_re_c, s_calc_im_c);
        end
        repeat (2) @(negedge sysclk);
        s_calc_done  = 1'b1;
        s_calc_depth = 11'd9;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (s_pix_valid === 1'b1) ok = 1;
            else @(negedge sysclk);
        end
        total++;
        if (!ok || {s_pix_x, s_pix_y, s_pix_depth, s_pix_last} !== {11'd0, 11'd0, 11'd9, 1'b1}) begin
            bad++;
            $display("[TB] FAIL one_pixel got=(%0d,%0d,%0d) last=%b want=(0,0,9) last=1",
                     s_pix_x, s_pix_y, s_pix_depth, s_pix_last);
        end
        @(negedge sysclk);
        total++;
        if (s_frame_done !== 1'b1 || s_busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL one_done got done=%b busy=%b want 1/0", s_frame_done, s_busy);
        end
        repeat (10) @(negedge sysclk);
        total++;
        if ((s_cs_count - c0) !== 1) begin
            bad++;
            $display("[TB] FAIL one_start_count got=%0d want=1", s_cs_count - c0);
        end
    endtask

    initial begin
        reset         = 1'b1;
        frame_start   = 1'b0;
        re_origin     = 32'hE0000000;
        im_origin     = 32'h10000000;
        step          = 32'h04000000;
        pix_ready     = 1'b1;
        model_lat     = 5;
        stale_mode    = 1'b0;
        s_frame_start = 1'b0;
        s_re_origin   = 32'h12345678;
        s_im_origin   = 32'hFEDCBA98;
        s_step        = 32'h00001000;
        s_calc_done   = 1'b0;
        s_calc_depth  = 11'd0;
        s_pix_ready   = 1'b1;

        test_reset();
        test_frame();
        test_backpressure();
        test_stale_done();
        test_frame_start_ignored();
        test_reset_mid_emit();
        test_single_pixel();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

endmodule
